// File: rtl/nios2_system_timer_pkg.sv
// Shared register map, bit positions and address-width helper for the
// multi-channel interval timer.
package nios2_system_timer_pkg;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_CONTROL = 2'd1,
        REG_PERIOD  = 2'd2,
        REG_SNAP    = 2'd3
    } reg_off_e;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;
    localparam int PRESC_LSB  = 8;

    localparam int STAT_TO    = 0;
    localparam int STAT_RUN   = 1;

    // Two offset bits per channel plus enough bits to index every channel.
    function automatic int addr_width(input int num_ch);
        return $clog2(num_ch) + 2;
    endfunction

endpackage

// File: rtl/nios2_system_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel timer.
interface nios2_system_multi_timer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_system_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO state and the
// CONTROL/PERIOD/SNAP registers, with a combinational read word.
module nios2_system_timer_channel
    import nios2_system_timer_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int          PRESC_W      = 8,
    parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  reg_off_e    reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] PERIOD_INIT = RESET_PERIOD[CNT_W-1:0];

    logic             ito;
    logic             cont;
    logic             run;
    logic             to;
    logic             force_reload;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] snap;
    logic             tick;
    logic             timeout;
    logic             wr_status;
    logic             wr_control;
    logic             wr_period;
    logic             wr_snap;
    logic             start;
    logic             stop;
    logic [31:0]      presc_field;
    logic             unused_wdata;

    assign wr_status  = wr_en && (reg_sel == REG_STATUS);
    assign wr_control = wr_en && (reg_sel == REG_CONTROL);
    assign wr_period  = wr_en && (reg_sel == REG_PERIOD);
    assign wr_snap    = wr_en && (reg_sel == REG_SNAP);
    assign start      = wr_control && wdata[CTRL_START];
    assign stop       = wr_control && wdata[CTRL_STOP];
    assign timeout    = tick && (count == '0);
    assign unused_wdata = ^wdata;

    generate
        if (PRESC_W > 0) begin : g_presc
            logic [PRESC_W-1:0] presc;
            logic [PRESC_W-1:0] presc_cnt;
            logic [PRESC_W-1:0] presc_nxt;

            // Reload from the value being written so a CONTROL write that sets
            // PRESC and START together times its first tick with the new PRESC.
            assign presc_nxt = wr_control ? wdata[PRESC_LSB +: PRESC_W] : presc;
            assign tick      = run && (presc_cnt == '0);
            assign presc_field = 32'(presc) << PRESC_LSB;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    presc     <= '0;
                    presc_cnt <= '0;
                end else begin
                    if (wr_control) begin
                        presc <= wdata[PRESC_LSB +: PRESC_W];
                    end
                    if (!run || wr_period || tick) begin
                        presc_cnt <= presc_nxt;
                    end else begin
                        presc_cnt <= presc_cnt - PRESC_W'(1);
                    end
                end
            end
        end else begin : g_no_presc
            assign tick        = run;
            assign presc_field = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ito          <= 1'b0;
            cont         <= 1'b0;
            run          <= 1'b0;
            to           <= 1'b0;
            force_reload <= 1'b0;
            period       <= PERIOD_INIT;
            count        <= PERIOD_INIT;
            snap         <= '0;
        end else begin
            force_reload <= wr_period;

            if (wr_control) begin
                ito  <= wdata[CTRL_ITO];
                cont <= wdata[CTRL_CONT];
            end
            if (wr_period) begin
                period <= wdata[CNT_W-1:0];
            end
            if (wr_snap) begin
                snap <= count;
            end

            if (force_reload) begin
                count <= period;
            end else if (tick) begin
                count <= timeout ? period : count - CNT_W'(1);
            end

            // A STATUS write beats a simultaneous timeout.
            if (wr_status) begin
                to <= 1'b0;
            end else if (timeout) begin
                to <= 1'b1;
            end

            if (wr_period) begin
                run <= 1'b0;
            end else if (start) begin
                run <= 1'b1;
            end else if (stop) begin
                run <= 1'b0;
            end else if (timeout && !cont) begin
                run <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS: begin
                rdata[STAT_TO]  = to;
                rdata[STAT_RUN] = run;
            end
            REG_CONTROL: rdata = presc_field | {30'b0, cont, ito};
            REG_PERIOD:  rdata[CNT_W-1:0] = period;
            REG_SNAP:    rdata[CNT_W-1:0] = snap;
            default:     rdata = '0;
        endcase
    end

    assign irq = to & ito;

endmodule

// File: rtl/nios2_system_multi_timer.sv
// Multi-channel interval timer: channel decode, per-channel instances,
// registered read mux and combined interrupt.
module nios2_system_multi_timer
    import nios2_system_timer_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          PRESC_W      = 8,
    parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios2_system_multi_timer_if.slave bus,
    output logic [NUM_CH-1:0]     irq_vec,
    output logic                  irq
);

    localparam int ADDR_W = addr_width(NUM_CH);
    localparam int CH_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    logic [CH_W-1:0] ch_sel;
    logic            wr_strobe;
    reg_off_e        reg_sel;
    logic [31:0]     ch_rdata [NUM_CH];
    logic [31:0]     rd_mux;

    assign wr_strobe = bus.chipselect && !bus.write_n;
    assign reg_sel   = reg_off_e'(bus.address[1:0]);

    generate
        if (ADDR_W > 2) begin : g_ch_sel
            assign ch_sel = bus.address[ADDR_W-1:2];
        end else begin : g_one_ch
            assign ch_sel = '0;
        end
    endgenerate

    // Channel indices at or above NUM_CH match no instance: writes drop, reads give 0.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nios2_system_timer_channel #(
            .CNT_W        (CNT_W),
            .PRESC_W      (PRESC_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_strobe && (ch_sel == CH_W'(i))),
            .reg_sel (reg_sel),
            .wdata   (bus.writedata),
            .rdata   (ch_rdata[i]),
            .irq     (irq_vec[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                rd_mux = ch_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |irq_vec;

endmodule
